// File: rtl/raymarch_frame_scheduler.sv
// raymarch_frame_scheduler: walks a WIDTH x HEIGHT raster, issues Q11.21 pixel coordinates under a credit limit, streams returned shades
// Ports: clk, rst_gen (sync active-low); start + cfg_* latched into rm_* on start in IDLE; busy/frame_done/err status;
//   rm_screen_x/y + rm_valid_in issue side; rm_valid_out + rm_shade_out return side (in order);
//   m_tdata/m_tvalid/m_tready/m_tuser(sof)/m_tlast(eol) AXI-S output.
// Macro RAYMARCH_SCHED_PERF_EN adds perf_frame_cycles: start-edge-to-frame_done cycle count of the last frame.
module raymarch_frame_scheduler #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int MAX_INFLIGHT = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_gen,
  input  logic        start,
  input  logic [95:0] cfg_camera_forward,
  input  logic [95:0] cfg_camera_right,
  input  logic [95:0] cfg_ray_origin,
  input  logic [95:0] cfg_light_pos,
  input  logic        cfg_sdf_sel,
  output logic        busy,
  output logic        frame_done,
  output logic        err,
  output logic [31:0] rm_screen_x,
  output logic [31:0] rm_screen_y,
  output logic        rm_valid_in,
  output logic [95:0] rm_camera_forward,
  output logic [95:0] rm_camera_right,
  output logic [95:0] rm_ray_origin,
  output logic [95:0] rm_light_pos,
  output logic        rm_sdf_sel,
  input  logic        rm_valid_out,
  input  logic [23:0] rm_shade_out,
  output logic [23:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
`ifdef RAYMARCH_SCHED_PERF_EN
  output logic        m_tlast,
  output logic [31:0] perf_frame_cycles
`else
  output logic        m_tlast
`endif
);
  localparam int XW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0] state, nxt;
  logic [XW-1:0] issue_x, ret_x;
  logic [YW-1:0] issue_y, ret_y;
  logic [IW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [25:0] mem [FIFO_DEPTH];
  logic issue, last_issue, ret_ok, pop, drained;
  // Credits cover both pipeline occupancy and FIFO slots, so a push can never find the FIFO full.
  assign issue = state == RUN && 32'(inflight) < MAX_INFLIGHT &&
                 32'(inflight) + 32'(fifo_count) < FIFO_DEPTH;
  assign last_issue = issue && issue_x == XW'(WIDTH - 1) && issue_y == YW'(HEIGHT - 1);
  assign ret_ok = rm_valid_out && inflight != '0;
  assign pop = m_tvalid && m_tready;
  assign drained = inflight == '0 && fifo_count == '0;
  always_ff @(posedge clk)
    state <= !rst_gen ? IDLE : nxt;
  always_comb
    nxt = state == IDLE  ? (start ? RUN : IDLE) :
          state == RUN   ? (last_issue ? DRAIN : RUN) :
          state == DRAIN ? (drained ? DONE : DRAIN) : IDLE;
  always_comb begin
    busy = state == RUN || state == DRAIN;
    frame_done = state == DONE;
    rm_valid_in = issue;
    rm_screen_x = 32'(issue_x) << 21;
    rm_screen_y = 32'(issue_y) << 21;
    m_tvalid = fifo_count != '0;
    m_tdata = mem[rd_ptr][25:2];
    m_tuser = mem[rd_ptr][1];
    m_tlast = mem[rd_ptr][0];
  end
  always_ff @(posedge clk) begin
    if (!rst_gen) begin
      rm_camera_forward <= '0;
      rm_camera_right <= '0;
      rm_ray_origin <= '0;
      rm_light_pos <= '0;
      rm_sdf_sel <= 1'b0;
      issue_x <= '0;
      issue_y <= '0;
      ret_x <= '0;
      ret_y <= '0;
      inflight <= '0;
      fifo_count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      err <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (issue) begin
        issue_x <= issue_x == XW'(WIDTH - 1) ? '0 : issue_x + 1'b1;
        if (issue_x == XW'(WIDTH - 1)) issue_y <= issue_y == YW'(HEIGHT - 1) ? '0 : issue_y + 1'b1;
      end
      inflight <= inflight + IW'(issue) - IW'(ret_ok);
      if (rm_valid_out && inflight == '0) err <= 1'b1;
      if (ret_ok) begin
        mem[wr_ptr] <= {rm_shade_out, ret_x == '0 && ret_y == '0, ret_x == XW'(WIDTH - 1)};
        wr_ptr <= wr_ptr + 1'b1;
        ret_x <= ret_x == XW'(WIDTH - 1) ? '0 : ret_x + 1'b1;
        if (ret_x == XW'(WIDTH - 1)) ret_y <= ret_y == YW'(HEIGHT - 1) ? '0 : ret_y + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(ret_ok) - CW'(pop);
      if (state == IDLE && start) begin
        rm_camera_forward <= cfg_camera_forward;
        rm_camera_right <= cfg_camera_right;
        rm_ray_origin <= cfg_ray_origin;
        rm_light_pos <= cfg_light_pos;
        rm_sdf_sel <= cfg_sdf_sel;
        issue_x <= '0;
        issue_y <= '0;
        ret_x <= '0;
        ret_y <= '0;
      end
    end
  end
`ifdef RAYMARCH_SCHED_PERF_EN
  logic [31:0] perf_cnt;
  // Latched on the DRAIN->DONE edge so the value is already valid while frame_done is high.
  always_ff @(posedge clk) begin
    if (!rst_gen) begin
      perf_cnt <= '0;
      perf_frame_cycles <= '0;
    end else begin
      perf_cnt <= state == IDLE && start ? '0 : busy ? perf_cnt + 1'b1 : perf_cnt;
      if (state == DRAIN && drained) perf_frame_cycles <= perf_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_raymarch_frame_scheduler.sv
// tb_raymarch_frame_scheduler: self-checking bench with a fixed-latency pipeline model and an output scoreboard
module tb_raymarch_frame_scheduler;
  localparam int W = 4, H = 2, MI = 2, FD = 4, LAT = 5;
  logic clk = 1'b0, rst_gen = 1'b0, start = 1'b0;
  logic [95:0] cf = '0, cr = '0, co = '0, cl = '0;
  logic csel = 1'b0;
  logic busy, frame_done, err, rm_valid_in, rm_sdf_sel, m_tvalid, m_tuser, m_tlast;
  logic [31:0] rm_screen_x, rm_screen_y;
  logic [95:0] rm_camera_forward, rm_camera_right, rm_ray_origin, rm_light_pos;
  logic rm_valid_out = 1'b0, m_tready = 1'b1;
  logic [23:0] rm_shade_out = '0, m_tdata;
`ifdef RAYMARCH_SCHED_PERF_EN
  logic [31:0] perf_frame_cycles;
`endif
  raymarch_frame_scheduler #(.WIDTH(W), .HEIGHT(H), .MAX_INFLIGHT(MI), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_gen(rst_gen), .start(start),
    .cfg_camera_forward(cf), .cfg_camera_right(cr), .cfg_ray_origin(co), .cfg_light_pos(cl), .cfg_sdf_sel(csel),
    .busy(busy), .frame_done(frame_done), .err(err),
    .rm_screen_x(rm_screen_x), .rm_screen_y(rm_screen_y), .rm_valid_in(rm_valid_in),
    .rm_camera_forward(rm_camera_forward), .rm_camera_right(rm_camera_right),
    .rm_ray_origin(rm_ray_origin), .rm_light_pos(rm_light_pos), .rm_sdf_sel(rm_sdf_sel),
    .rm_valid_out(rm_valid_out), .rm_shade_out(rm_shade_out),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tuser(m_tuser),
`ifdef RAYMARCH_SCHED_PERF_EN
    .m_tlast(m_tlast), .perf_frame_cycles(perf_frame_cycles)
`else
    .m_tlast(m_tlast)
`endif
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, n_issue = 0, exp_ix = 0, exp_iy = 0, outstanding = 0, n_beats = 0, n_done = 0;
  int issue_cyc [64];
  logic was_rst = 1'b0, inject = 1'b0, stall_prev = 1'b0;
  logic [25:0] held = '0;
  logic [25:0] sb [$];
  logic [24:0] pipe [LAT];
  initial forever begin
    @(posedge clk);
    cyc++;
    was_rst = !rst_gen;
  end
  initial begin
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    forever begin
      logic [24:0] o;
      int idx;
      @(negedge clk);
      if (was_rst) begin
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        rm_valid_out = inject;
        inject = 1'b0;
        outstanding = 0;
      end else begin
        o = pipe[LAT-1];
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        idx = int'(rm_screen_y >> 21) * W + int'(rm_screen_x >> 21);
        pipe[0] = {rm_valid_in, 24'(idx)};
        rm_valid_out = o[24] | inject;
        rm_shade_out = o[23:0];
        inject = 1'b0;
        if (o[24]) outstanding--;
        if (rm_valid_in) begin
          n_cmp += 3;
          if (rm_screen_x !== 32'(exp_ix) * 32'h0020_0000) begin
            n_bad++;
            $display("FAIL issue_x #%0d: got %h want %h", n_issue, rm_screen_x, 32'(exp_ix) * 32'h0020_0000);
          end
          if (rm_screen_y !== 32'(exp_iy) * 32'h0020_0000) begin
            n_bad++;
            $display("FAIL issue_y #%0d: got %h want %h", n_issue, rm_screen_y, 32'(exp_iy) * 32'h0020_0000);
          end
          outstanding++;
          if (outstanding > MI) begin
            n_bad++;
            $display("FAIL credit: outstanding %0d exceeds %0d", outstanding, MI);
          end
          if (n_issue < 64) issue_cyc[n_issue] = cyc;
          n_issue++;
          exp_ix = exp_ix == W - 1 ? 0 : exp_ix + 1;
          if (exp_ix == 0) exp_iy = exp_iy == H - 1 ? 0 : exp_iy + 1;
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (was_rst) stall_prev = 1'b0;
    if (stall_prev) begin
      n_cmp++;
      if (!m_tvalid || {m_tdata, m_tuser, m_tlast} !== held) begin
        n_bad++;
        $display("FAIL stall_stable: got v=%b %h want v=1 %h", m_tvalid, {m_tdata, m_tuser, m_tlast}, held);
      end
    end
    if (m_tvalid && m_tready) begin
      n_cmp++;
      n_beats++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL beat_extra: got %h want no beat", {m_tdata, m_tuser, m_tlast});
      end else begin
        logic [25:0] e;
        e = sb.pop_front();
        if ({m_tdata, m_tuser, m_tlast} !== e) begin
          n_bad++;
          $display("FAIL beat: got data=%h user=%b last=%b want data=%h user=%b last=%b",
                   m_tdata, m_tuser, m_tlast, e[25:2], e[1], e[0]);
        end
      end
    end
    stall_prev = m_tvalid && !m_tready;
    held = {m_tdata, m_tuser, m_tlast};
    if (frame_done) n_done++;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic new_frame();
    n_issue = 0;
    exp_ix = 0;
    exp_iy = 0;
  endtask
  task automatic kick();
    for (int i = 0; i < W * H; i++) sb.push_back({24'(i), i == 0, (i % W) == W - 1});
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(output int ok, output int dc);
    ok = 0;
    dc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1;
        dc = cyc;
        break;
      end
    end
  endtask
  task automatic test_reset();
    rst_gen = 1'b0;
    cf = {$urandom, $urandom, $urandom};
    cl = {$urandom, $urandom, $urandom};
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    n_cmp += 8;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", frame_done); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
    if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
    if (rm_valid_in !== 1'b0) begin n_bad++; $display("FAIL rst_valid_in: got %b want 0", rm_valid_in); end
    if (rm_light_pos !== '0) begin n_bad++; $display("FAIL rst_light: got %h want 0", rm_light_pos); end
    if (rm_camera_forward !== '0) begin n_bad++; $display("FAIL rst_fwd: got %h want 0", rm_camera_forward); end
    if ({m_tdata, m_tuser, m_tlast} !== '0) begin n_bad++; $display("FAIL rst_tdata: got %h want 0", m_tdata); end
    rst_gen = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask
  task automatic test_basic_frame();
    int ok, dc, nd0, nb0;
    m_tready = 1'b1;
    cf = {$urandom, $urandom, $urandom};
    cr = {$urandom, $urandom, $urandom};
    co = {$urandom, $urandom, $urandom};
    cl = {$urandom, $urandom, $urandom};
    csel = 1'b1;
    new_frame();
    nd0 = n_done;
    nb0 = n_beats;
    kick();
    wait_done(ok, dc);
    repeat (3) tick();
    n_cmp += 11;
    if (ok != 1) begin n_bad++; $display("FAIL basic_done: got no frame_done want pulse"); end
    if (n_issue != W * H) begin n_bad++; $display("FAIL basic_issues: got %0d want %0d", n_issue, W * H); end
    if (n_beats - nb0 != W * H) begin n_bad++; $display("FAIL basic_beats: got %0d want %0d", n_beats - nb0, W * H); end
    if (n_done - nd0 != 1) begin n_bad++; $display("FAIL basic_done_cnt: got %0d want 1", n_done - nd0); end
    if (sb.size() != 0) begin n_bad++; $display("FAIL basic_sb: got %0d left want 0", sb.size()); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy: got %b want 0", busy); end
    if (rm_light_pos !== cl) begin n_bad++; $display("FAIL basic_light: got %h want %h", rm_light_pos, cl); end
    if (rm_camera_right !== cr || rm_ray_origin !== co || rm_camera_forward !== cf) begin
      n_bad++; $display("FAIL basic_cfg: got %h want %h", rm_camera_right, cr);
    end
    if (rm_sdf_sel !== 1'b1) begin n_bad++; $display("FAIL basic_sel: got %b want 1", rm_sdf_sel); end
    if (issue_cyc[1] - issue_cyc[0] != 1) begin
      n_bad++; $display("FAIL credit_gap1: got %0d want 1", issue_cyc[1] - issue_cyc[0]);
    end
    if (issue_cyc[2] - issue_cyc[0] != LAT + 1) begin
      n_bad++; $display("FAIL credit_gap2: got %0d want %0d", issue_cyc[2] - issue_cyc[0], LAT + 1);
    end
  endtask
  task automatic test_backpressure();
    int ok, dc, nb0;
    new_frame();
    nb0 = n_beats;
    m_tready = 1'b0;
    kick();
    repeat (30) tick();
    n_cmp += 6;
    if (n_issue != FD) begin n_bad++; $display("FAIL bp_issues: got %0d want %0d", n_issue, FD); end
    if (rm_valid_in !== 1'b0) begin n_bad++; $display("FAIL bp_valid_in: got %b want 0", rm_valid_in); end
    if (m_tvalid !== 1'b1) begin n_bad++; $display("FAIL bp_tvalid: got %b want 1", m_tvalid); end
    if (m_tdata !== 24'd0 || m_tuser !== 1'b1) begin
      n_bad++; $display("FAIL bp_head: got %h/%b want 0/1", m_tdata, m_tuser);
    end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_busy: got %b want 1", busy); end
    if (n_beats != nb0) begin n_bad++; $display("FAIL bp_beats: got %0d want %0d", n_beats, nb0); end
    m_tready = 1'b1;
    wait_done(ok, dc);
    tick();
    n_cmp += 4;
    if (ok != 1) begin n_bad++; $display("FAIL bp_done: got no frame_done want pulse"); end
    if (n_issue != W * H) begin n_bad++; $display("FAIL bp_issues_all: got %0d want %0d", n_issue, W * H); end
    if (n_beats - nb0 != W * H) begin n_bad++; $display("FAIL bp_beats_all: got %0d want %0d", n_beats - nb0, W * H); end
    if (sb.size() != 0) begin n_bad++; $display("FAIL bp_sb: got %0d left want 0", sb.size()); end
  endtask
  task automatic test_config_latch();
    int ok, dc;
    logic [95:0] a, b;
    a = {$urandom, $urandom, $urandom};
    b = ~a;
    cl = a;
    new_frame();
    kick();
    repeat (4) tick();
    cl = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp += 2;
    if (rm_light_pos !== a) begin n_bad++; $display("FAIL latch_hold: got %h want %h", rm_light_pos, a); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL latch_busy: got %b want 1", busy); end
    wait_done(ok, dc);
    tick();
    n_cmp += 3;
    if (ok != 1) begin n_bad++; $display("FAIL latch_done: got no frame_done want pulse"); end
    if (n_issue != W * H) begin n_bad++; $display("FAIL latch_issues: got %0d want %0d", n_issue, W * H); end
    if (sb.size() != 0) begin n_bad++; $display("FAIL latch_sb: got %0d left want 0", sb.size()); end
    new_frame();
    kick();
    n_cmp++;
    if (rm_light_pos !== b) begin n_bad++; $display("FAIL latch_new: got %h want %h", rm_light_pos, b); end
    wait_done(ok, dc);
    tick();
    n_cmp++;
    if (ok != 1) begin n_bad++; $display("FAIL latch_done2: got no frame_done want pulse"); end
  endtask
  task automatic test_perf();
`ifdef RAYMARCH_SCHED_PERF_EN
    int ok, dc, e0, d1, d2;
    logic [31:0] p1;
    m_tready = 1'b1;
    new_frame();
    kick();
    e0 = cyc;
    wait_done(ok, dc);
    d1 = dc - e0;
    p1 = perf_frame_cycles;
    tick();
    new_frame();
    kick();
    e0 = cyc;
    wait_done(ok, dc);
    d2 = dc - e0;
    tick();
    n_cmp += 3;
    if (p1 !== 32'(d1)) begin n_bad++; $display("FAIL perf1: got %0d want %0d", p1, d1); end
    if (perf_frame_cycles !== 32'(d2)) begin n_bad++; $display("FAIL perf2: got %0d want %0d", perf_frame_cycles, d2); end
    if (perf_frame_cycles !== p1) begin n_bad++; $display("FAIL perf_stable: got %0d want %0d", perf_frame_cycles, p1); end
`endif
  endtask
  task automatic test_reset_midframe();
    int seen;
    m_tready = 1'b1;
    new_frame();
    kick();
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_issue >= 3) begin
        seen = 1;
        break;
      end
    end
    n_cmp++;
    if (seen != 1) begin n_bad++; $display("FAIL mid_issues: got %0d want >=3", n_issue); end
    rst_gen = 1'b0;
    tick();
    rst_gen = 1'b1;
    sb.delete();
    new_frame();
    n_cmp += 4;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL mid_tvalid: got %b want 0", m_tvalid); end
    if (rm_valid_in !== 1'b0) begin n_bad++; $display("FAIL mid_valid_in: got %b want 0", rm_valid_in); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL mid_err0: got %b want 0", err); end
    repeat (8) tick();
    n_cmp++;
    if (err !== 1'b0 || m_tvalid !== 1'b0) begin
      n_bad++; $display("FAIL mid_quiet: got err=%b tvalid=%b want 0/0", err, m_tvalid);
    end
    inject = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL spurious_err: got %b want 1", err); end
    repeat (3) tick();
    n_cmp++;
    if (err !== 1'b1 || m_tvalid !== 1'b0) begin
      n_bad++; $display("FAIL err_sticky: got err=%b tvalid=%b want 1/0", err, m_tvalid);
    end
    rst_gen = 1'b0;
    tick();
    rst_gen = 1'b1;
    tick();
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", err); end
  endtask
  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_config_latch();
    test_perf();
    test_reset_midframe();
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
